ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter on the `clock_25` domain. It sends one command byte to the keyboard, such as LED set (0xED), echo (0xEE) or reset (0xFF), over the same open-collector PS2_CLK/PS2_DAT pair the keyboard receiver listens on. It produces active-high drive-low enables, which the top level converts to tri-states (`PS2_CLK = clk_oe ? 1'b0 : 1'bz`). `tx_busy` gates the receiver so that no transmit-phase clocks are decoded as scancodes.

---
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, sends start/8 data/odd parity/stop
// on device clock falls, then checks the device ACK. Outputs are open-collector drive-low enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int START_LEAD     = 25,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FLT_LAST  = FW'(FILTER_LEN - 1);
    localparam logic [19:0]   START_AT  = 20'(INHIBIT_CYCLES - START_LEAD - 1);
    localparam logic [19:0]   INH_LAST  = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0]   TO_LAST   = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_DATA,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic [FW-1:0] clk_fcnt;
    logic [FW-1:0] dat_fcnt;
    logic          clk_filt;
    logic          dat_filt;
    logic          clk_filt_q;
    logic          fall;
    logic          timed_out;
    logic [19:0]   cnt;
    logic [3:0]    idx;
    logic [9:0]    frame;
    logic          err_flag;

    // Lines idle high, so synchronizers and filters come out of reset at 1.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_fcnt   <= '0;
            dat_fcnt   <= '0;
            clk_filt   <= 1'b1;
            dat_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk_i};
            dat_sync   <= {dat_sync[0], ps2_dat_i};
            clk_filt_q <= clk_filt;

            if (clk_sync[1] == clk_filt) begin
                clk_fcnt <= '0;
            end else if (clk_fcnt == FLT_LAST) begin
                clk_filt <= clk_sync[1];
                clk_fcnt <= '0;
            end else begin
                clk_fcnt <= clk_fcnt + 1'b1;
            end

            if (dat_sync[1] == dat_filt) begin
                dat_fcnt <= '0;
            end else if (dat_fcnt == FLT_LAST) begin
                dat_filt <= dat_sync[1];
                dat_fcnt <= '0;
            end else begin
                dat_fcnt <= dat_fcnt + 1'b1;
            end
        end
    end

    assign fall      = clk_filt_q & ~clk_filt;
    assign timed_out = (state == S_DATA || state == S_ACK || state == S_WAIT_IDLE) && (cnt == TO_LAST);
    assign tx_busy   = ~tx_ready;

    // Handshake: a byte is taken on any cycle where tx_valid & tx_ready; tx_ready is a register
    // that stays low through the tx_done cycle and returns one cycle later.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            frame      <= '0;
            err_flag   <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (timed_out) begin
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                tx_done    <= 1'b1;
                tx_error   <= 1'b1;
                state      <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        if (!tx_ready) begin
                            tx_ready <= 1'b1;
                        end else if (tx_valid) begin
                            frame      <= {1'b1, ~^tx_data, tx_data};
                            cnt        <= '0;
                            err_flag   <= 1'b0;
                            tx_ready   <= 1'b0;
                            ps2_clk_oe <= 1'b1;
                            state      <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == START_AT) ps2_dat_oe <= 1'b1;
                        if (cnt == INH_LAST) begin
                            ps2_clk_oe <= 1'b0;
                            cnt        <= '0;
                            idx        <= '0;
                            state      <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        cnt <= cnt + 1'b1;
                        if (fall) begin
                            cnt        <= '0;
                            ps2_dat_oe <= ~frame[0];
                            frame      <= {1'b0, frame[9:1]};
                            idx        <= idx + 1'b1;
                            if (idx == 4'd9) state <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        cnt <= cnt + 1'b1;
                        if (fall) begin
                            err_flag <= dat_filt;
                            cnt      <= '0;
                            state    <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        cnt <= cnt + 1'b1;
                        if (fall) cnt <= '0;
                        if (clk_filt && dat_filt) begin
                            tx_done  <= 1'b1;
                            tx_error <= err_flag;
                            state    <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus with a behavioural keyboard clocking at 40 cycles,
// a vector table of frames plus hand sequences for timeout and mid-frame reset.
module tb_ps2_host_tx;

    logic       clock_25 = 1'b0;
    logic       reset;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       dev_clk_low;
    logic       dev_dat_low;
    logic       clk_pin;
    logic       dat_pin;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_bad = 0;

    assign clk_pin = ~(ps2_clk_oe | dev_clk_low);
    assign dat_pin = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(100),
        .START_LEAD    (10),
        .TIMEOUT_CYCLES(2000),
        .FILTER_LEN    (4)
    ) dut (
        .clock_25  (clock_25),
        .reset     (reset),
        .ps2_clk_i (clk_pin),
        .ps2_dat_i (dat_pin),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    // clock / reset
    always #5 clock_25 = ~clock_25;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    always @(negedge clock_25) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_busy !== ~tx_ready) busy_bad++;
    end

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        int          glitch_clk;
        bit          toggle;
        logic [10:0] exp_bits;
        bit          exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_25);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: present a byte for one cycle, then scramble tx_data
    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tx_data  = 8'hA5;
    endtask

    // Keyboard model: measures the inhibit, then clocks 11 times; samples on each release.
    task automatic dev_frame(input bit ack, input int glitch_clk, input int abort_after,
                             input bit toggle_req, output logic [10:0] got,
                             output int width, output int lead, output bit ok);
        int n;
        got   = '0;
        width = 0;
        lead  = 0;
        ok    = 1'b1;
        n     = 0;
        while (ps2_clk_oe === 1'b1 && n < 500) begin
            width++;
            if (ps2_dat_oe === 1'b1) lead++;
            tick(1);
            n++;
        end
        if (n >= 500 || width == 0) begin
            ok = 1'b0;
            return;
        end
        got[0] = dat_pin;
        for (int k = 1; k <= 11; k++) begin
            for (int h = 0; h < 20; h++) begin
                tick(1);
                if (k == glitch_clk && h == 8)  dev_clk_low = 1'b1;
                if (k == glitch_clk && h == 10) dev_clk_low = 1'b0;
                if (k == 11 && h == 10 && ack)  dev_dat_low = 1'b1;
                if (toggle_req && k == 3 && h == 4) begin
                    tx_valid = 1'b1;
                    tx_data  = 8'h55;
                end
                if (toggle_req && k == 3 && h == 7) tx_valid = 1'b0;
            end
            dev_clk_low = 1'b1;
            tick(20);
            if (k == abort_after) return;
            dev_clk_low = 1'b0;
            if (k <= 10) got[k] = dat_pin;
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [10:0] got;
        int          width;
        int          lead;
        bit          ok;
        int          d0;
        int          n;
        check({tag, "_ready_before"}, 32'(tx_ready), 32'd1);
        d0 = done_cnt;
        send(v.data);
        check({tag, "_clk_pull"}, 32'(ps2_clk_oe), 32'd1);
        check({tag, "_busy"}, 32'(tx_busy), 32'd1);
        dev_frame(v.ack, v.glitch_clk, 0, v.toggle, got, width, lead, ok);
        check({tag, "_release_seen"}, 32'(ok), 32'd1);
        check({tag, "_clk_low_width"}, 32'(width), 32'd100);
        check({tag, "_start_lead"}, 32'(lead), 32'd10);
        check({tag, "_bits"}, 32'(got), 32'(v.exp_bits));
        n = 0;
        while (tx_done !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        check({tag, "_done_seen"}, 32'(tx_done), 32'd1);
        check({tag, "_error"}, 32'(tx_error), 32'(v.exp_err));
        check({tag, "_ready_in_done"}, 32'(tx_ready), 32'd0);
        tick(1);
        check({tag, "_ready_after"}, 32'(tx_ready), 32'd1);
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        tick(20);
        check({tag, "_idle_clk_oe"}, 32'(ps2_clk_oe), 32'd0);
    endtask

    initial begin
        logic [10:0] got;
        int          width;
        int          lead;
        bit          ok;
        int          d0;
        int          t;
        bit          seen;

        // expected bits: {stop, parity, b7..b0, start}
        vecs[0] = '{8'hED, 1'b1, 0, 1'b0, 11'b1_1_11101101_0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 0, 1'b0, 11'b1_1_00000000_0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 0, 1'b0, 11'b1_1_11111111_0, 1'b0};
        vecs[3] = '{8'hED, 1'b0, 0, 1'b0, 11'b1_1_11101101_0, 1'b1};
        vecs[4] = '{8'h01, 1'b1, 5, 1'b1, 11'b1_0_00000001_0, 1'b0};

        reset       = 1'b1;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        tick(3);
        reset = 1'b0;
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_error", 32'(tx_error), 32'd0);
        tick(10);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // silent device: timeout 2000 cycles after the clock release
        d0 = done_cnt;
        send(8'hEE);
        t = 0;
        while (ps2_clk_oe === 1'b1 && t < 500) begin
            tick(1);
            t++;
        end
        check("silent_release", 32'(ps2_clk_oe), 32'd0);
        t = 0;
        while (tx_done !== 1'b1 && t < 2200) begin
            tick(1);
            t++;
        end
        check("silent_timeout_cycles", 32'(t), 32'd2000);
        check("silent_error", 32'(tx_error), 32'd1);
        check("silent_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("silent_dat_oe", 32'(ps2_dat_oe), 32'd0);
        tick(1);
        check("silent_ready_after", 32'(tx_ready), 32'd1);
        check("silent_done_count", 32'(done_cnt - d0), 32'd1);
        tick(10);

        // reset after fall 4 of 0x00 (bit 3 is 0, so data is being pulled)
        d0 = done_cnt;
        send(8'h00);
        dev_frame(1'b1, 0, 4, 1'b0, got, width, lead, ok);
        check("abort_release_seen", 32'(ok), 32'd1);
        check("abort_dat_before", 32'(ps2_dat_oe), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("abort_dat_oe", 32'(ps2_dat_oe), 32'd0);
        dev_clk_low = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (tx_done === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_done_count", 32'(done_cnt - d0), 32'd0);
        check("abort_ready", 32'(tx_ready), 32'd1);
        run_vec(vecs[2], "after_abort");

        check("busy_is_not_ready", 32'(busy_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
